// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter serialising fetch/LSU access to one single-ported memory (MEM_ARBITER_ROUND_ROBIN_EN selects round-robin ties)
module mem_arbiter #(
  parameter int WORD_SIZE    = 32,
  parameter int ADDRESS_SIZE = 32
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    Req0,
  input  logic                    Req1,
  input  logic                    Write0,
  input  logic                    Write1,
  input  logic [ADDRESS_SIZE-1:0] Addr0,
  input  logic [ADDRESS_SIZE-1:0] Addr1,
  input  logic [WORD_SIZE-1:0]    WData0,
  input  logic [WORD_SIZE-1:0]    WData1,
  output logic                    Gnt0,
  output logic                    Gnt1,
  output logic                    Ack0,
  output logic                    Ack1,
  output logic [WORD_SIZE-1:0]    RData0,
  output logic [WORD_SIZE-1:0]    RData1,
  output logic [ADDRESS_SIZE-1:0] MemAddress,
  output logic [WORD_SIZE-1:0]    MemWriteData,
  output logic                    MemRead,
  output logic                    MemWrite,
  input  logic [WORD_SIZE-1:0]    MemReadData,
  output logic                    Busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE} state_t;
  state_t state, state_nx;
  logic cmd_write, cmd_port, win, accept;
  logic [ADDRESS_SIZE-1:0] cmd_addr;
  logic [WORD_SIZE-1:0] cmd_wdata;
  assign accept = (state == IDLE) && (Req0 || Req1);
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  logic last;
  assign win = (Req0 && Req1) ? ~last : ~Req0;
  // remember the last granted port so ties alternate
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) last <= 1'b1;
    else if (accept) last <= win;
`else
  assign win = ~Req0;
`endif
  // state register
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= state_nx;
  // next state and memory-side decode, all from registered state
  always_comb begin
    state_nx     = state;
    Gnt0         = 1'b0;
    Gnt1         = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    Busy         = state != IDLE;
    MemAddress   = cmd_addr;
    MemWriteData = cmd_wdata;
    state_nx     = state == IDLE ? (accept ? ACCESS : IDLE) : state == ACCESS ? CAPTURE : IDLE;
    Gnt0         = (state == ACCESS) && !cmd_port;
    Gnt1         = (state == ACCESS) && cmd_port;
    MemRead      = (state != IDLE) && !cmd_write;
    MemWrite     = (state == ACCESS) && cmd_write;
  end
  // latch the winner's command at accept; return data and ack at the end of CAPTURE
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      cmd_write <= 1'b0;
      cmd_port  <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      Ack0      <= 1'b0;
      Ack1      <= 1'b0;
      RData0    <= '0;
      RData1    <= '0;
    end else begin
      if (accept) begin
        cmd_port  <= win;
        cmd_write <= win ? Write1 : Write0;
        cmd_addr  <= win ? Addr1 : Addr0;
        cmd_wdata <= win ? WData1 : WData0;
      end
      Ack0 <= (state == CAPTURE) && !cmd_port;
      Ack1 <= (state == CAPTURE) && cmd_port;
      if (state == CAPTURE && !cmd_write && !cmd_port) RData0 <= MemReadData;
      if (state == CAPTURE && !cmd_write && cmd_port) RData1 <= MemReadData;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a synchronous-read memory model
module tb_mem_arbiter;
  logic clk, rstn, Req0, Req1, Write0, Write1;
  logic [31:0] Addr0, Addr1, WData0, WData1, RData0, RData1;
  logic Gnt0, Gnt1, Ack0, Ack1, MemRead, MemWrite, Busy;
  logic [31:0] MemAddress, MemWriteData, MemReadData;
  logic [31:0] mem [0:2047];
  typedef struct {int port; bit rd; logic [31:0] data;} exp_t;
  exp_t aq[$];
  int gq[$];
  int n_chk = 0, n_fail = 0, cyc = 0, wr_cnt = 0;
  int gcyc [2];
  logic [31:0] wr_addr = 0;

  mem_arbiter dut (
    .clk(clk), .rstn(rstn), .Req0(Req0), .Req1(Req1), .Write0(Write0), .Write1(Write1),
    .Addr0(Addr0), .Addr1(Addr1), .WData0(WData0), .WData1(WData1),
    .Gnt0(Gnt0), .Gnt1(Gnt1), .Ack0(Ack0), .Ack1(Ack1), .RData0(RData0), .RData1(RData1),
    .MemAddress(MemAddress), .MemWriteData(MemWriteData), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemReadData(MemReadData), .Busy(Busy)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (MemWrite) mem[MemAddress[10:0]] <= MemWriteData;
    if (MemRead) MemReadData <= mem[MemAddress[10:0]];
  end

  always @(posedge clk)
    if (rstn) assert (!(MemRead && MemWrite)) else begin
      n_fail++;
      $display("FAIL mem_rw_exclusive: MemRead=%b MemWrite=%b required not both 1", MemRead, MemWrite);
    end

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endfunction

  always @(negedge clk) begin
    if (MemWrite) begin
      wr_cnt <= wr_cnt + 1;
      wr_addr <= MemAddress;
    end
    if (Gnt0 || Gnt1) begin
      int p;
      p = Gnt1 ? 1 : 0;
      chk("gnt_onehot", {31'd0, Gnt0 ^ Gnt1}, 1);
      chk("gnt_expected", {31'd0, gq.size() > 0}, 1);
      if (gq.size() > 0) chk("gnt_port", p, gq.pop_front());
      gcyc[p] = cyc;
    end
    if (Ack0 || Ack1) begin
      int p;
      exp_t e;
      p = Ack1 ? 1 : 0;
      chk("ack_expected", {31'd0, aq.size() > 0}, 1);
      if (aq.size() > 0) begin
        e = aq.pop_front();
        chk("ack_port", p, e.port);
        chk("ack_latency", cyc, gcyc[p] + 2);
        if (e.rd) chk("ack_rdata", p ? RData1 : RData0, e.data);
      end
    end
  end

  task automatic issue(input int p, input bit w, input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      Write0 = w; Addr0 = a; WData0 = d; Req0 = 1;
    end else begin
      Write1 = w; Addr1 = a; WData1 = d; Req1 = 1;
    end
  endtask

  task automatic expect_acc(input int p, input bit rd, input logic [31:0] d);
    exp_t e;
    e.port = p; e.rd = rd; e.data = d;
    gq.push_back(p);
    aq.push_back(e);
  endtask

  task automatic run();
    bit done;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (Gnt0) Req0 = 0;
      if (Gnt1) Req1 = 0;
      if (!Req0 && !Req1 && !Busy && !Ack0 && !Ack1) done = 1;
    end
    chk("run_done", {31'd0, done}, 1);
  endtask

  initial begin
    int w0;
    bit seen;
    rstn = 0; Req0 = 1; Req1 = 0; Write0 = 0; Write1 = 0;
    Addr0 = 0; Addr1 = 0; WData0 = 0; WData1 = 0;
    repeat (3) @(negedge clk);
    chk("rst_gnt0", {31'd0, Gnt0}, 0);
    chk("rst_ack0", {31'd0, Ack0}, 0);
    chk("rst_memread", {31'd0, MemRead}, 0);
    chk("rst_memwrite", {31'd0, MemWrite}, 0);
    chk("rst_busy", {31'd0, Busy}, 0);
    chk("rst_rdata0", RData0, 0);
    chk("rst_memaddr", MemAddress, 0);
    Req0 = 0;
    rstn = 1;
    @(negedge clk);
    w0 = wr_cnt;
    issue(1, 1, 1000, 32'hDEADBEEF);
    expect_acc(1, 0, 0);
    run();
    chk("wr_pulses", wr_cnt - w0, 1);
    chk("wr_addr", wr_addr, 1000);
    chk("mem_1000", mem[1000], 32'hDEADBEEF);
    issue(1, 0, 1000, 0);
    expect_acc(1, 1, 32'hDEADBEEF);
    run();
    issue(0, 1, 1004, 32'hA1A1A1A1);
    expect_acc(0, 0, 0);
    run();
    issue(1, 1, 1008, 32'hB2B2B2B2);
    expect_acc(1, 0, 0);
    run();
    issue(1, 1, 1010, 32'h55555555);
    expect_acc(1, 0, 0);
    run();
    issue(0, 0, 1004, 0);
    issue(1, 0, 1008, 0);
    expect_acc(0, 1, 32'hA1A1A1A1);
    expect_acc(1, 1, 32'hB2B2B2B2);
    run();
    issue(0, 0, 1004, 0);
    issue(1, 0, 1008, 0);
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      if (k % 2 == 1) expect_acc(1, 1, 32'hB2B2B2B2);
      else expect_acc(0, 1, 32'hA1A1A1A1);
`else
      expect_acc(0, 1, 32'hA1A1A1A1);
`endif
    end
    repeat (12) @(negedge clk);
    Req0 = 0;
    Req1 = 0;
    run();
    issue(1, 1, 1010, 32'h12345678);
    gq.push_back(1);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = Gnt1;
    end
    chk("midrst_gnt_seen", {31'd0, seen}, 1);
    #2 rstn = 0;
    #1;
    chk("midrst_busy", {31'd0, Busy}, 0);
    chk("midrst_memwrite", {31'd0, MemWrite}, 0);
    chk("midrst_gnt1", {31'd0, Gnt1}, 0);
    Req1 = 0;
    @(negedge clk);
    rstn = 1;
    repeat (4) @(negedge clk);
    chk("midrst_idle", {31'd0, Busy}, 0);
    chk("midrst_mem_1010", mem[1010], 32'h55555555);
    chk("gq_drained", gq.size(), 0);
    chk("aq_drained", aq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
